// File: rtl/inst_sram_if.sv
// Fetch-side instruction SRAM request port: the IF stage drives requests,
// and the memory responder returns read data one cycle later.
interface inst_sram_if;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/inst_sram_responder.sv
// Single-port instruction SRAM with one-cycle read latency, read-first writes,
// sticky out-of-window error capture and saturating access counters.
module inst_sram_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h1C00_0000,
  parameter int          AW        = 16,
  parameter logic [31:0] ERR_DATA  = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        resetn,
  inst_sram_if.slave  bus,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [0:DEPTH-1];

  logic [31:0]   off;
  logic          in_win;
  logic [AW-1:0] idx;
  logic          is_rd;
  logic          is_wr;
  logic          mem_we;
  logic [31:0]   mem_rd_data;
  logic          unused_addr_lsb;

  logic [31:0] rdata_d,    rdata_q;
  logic        err_d,      err_q;
  logic [31:0] err_addr_d, err_addr_q;
  logic [31:0] rd_cnt_d,   rd_cnt_q;
  logic [31:0] wr_cnt_d,   wr_cnt_q;

  // Window test is done on the wrapped offset so addresses below the base fall out.
  assign off             = bus.sram_addr - ADDR_BASE;
  assign in_win          = (off[31:AW+2] == '0);
  assign idx             = off[AW+1:2];
  assign unused_addr_lsb = ^off[1:0];

  assign is_rd       = bus.sram_en && (bus.sram_we == 4'b0000);
  assign is_wr       = bus.sram_en && (bus.sram_we != 4'b0000);
  assign mem_we      = is_wr && in_win;
  assign mem_rd_data = mem[idx];

  always_comb begin
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;

    if (is_rd) begin
      rdata_d = in_win ? mem_rd_data : ERR_DATA;
    end else if (mem_we) begin
      rdata_d = mem_rd_data;
    end

    // err_addr latches only the first offending address after reset.
    if (bus.sram_en && !in_win) begin
      err_d = 1'b1;
      if (!err_q) begin
        err_addr_d = bus.sram_addr;
      end
    end

    if (is_rd && (rd_cnt_q != 32'hFFFF_FFFF)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (is_wr && (wr_cnt_q != 32'hFFFF_FFFF)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Array is not reset; requests arriving during reset must not disturb it.
  always_ff @(posedge clk) begin
    if (resetn && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sram_we[i]) begin
          mem[idx][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.sram_rdata = rdata_q;
  assign err            = err_q;
  assign err_addr       = err_addr_q;
  assign rd_cnt         = rd_cnt_q;
  assign wr_cnt         = wr_cnt_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Randomized and directed bench for inst_sram_responder against a word-level
// memory model held in an associative array.
module tb_inst_sram_responder;

  localparam logic [31:0] BASE      = 32'h1C00_0000;
  localparam logic [31:0] ERR_WORD  = 32'h0340_0000;
  localparam logic [31:0] WIN_BYTES = 32'h0004_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  inst_sram_if bus ();

  inst_sram_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .err      (err),
    .err_addr (err_addr),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mdl [int unsigned];
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic [31:0] exp_err_addr;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;
  bit          rdata_known;
  int          n_tests;
  int          n_fail;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  function automatic bit in_window(input logic [31:0] addr);
    logic [31:0] o;
    o = addr - BASE;
    return o < WIN_BYTES;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check_all(input string tag);
    if (rdata_known) check32({tag, "_rdata"}, bus.sram_rdata, exp_rdata);
    check32({tag, "_err"},      {31'd0, err}, {31'd0, exp_err});
    check32({tag, "_err_addr"}, err_addr, exp_err_addr);
    check32({tag, "_rd_cnt"},   rd_cnt, exp_rd);
    check32({tag, "_wr_cnt"},   wr_cnt, exp_wr);
  endtask

  // One clock: drive request, advance past the edge, update the model, compare.
  task automatic cycle(input bit rst_n, input bit en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int unsigned w;
    logic [31:0] old;
    logic [31:0] nw;
    resetn         = rst_n;
    bus.sram_en    = en;
    bus.sram_we    = we;
    bus.sram_addr  = addr;
    bus.sram_wdata = wd;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_rdata    = '0;
      rdata_known  = 1'b1;
      exp_err      = 1'b0;
      exp_err_addr = '0;
      exp_rd       = '0;
      exp_wr       = '0;
    end else if (en) begin
      if (in_window(addr)) begin
        w   = (addr - BASE) >> 2;
        old = mdl.exists(w) ? mdl[w] : 32'hx;
        exp_rdata   = old;
        rdata_known = mdl.exists(w);
        if (we == 4'b0000) begin
          exp_rd = sat_inc(exp_rd);
        end else begin
          nw = old;
          for (int i = 0; i < 4; i++)
            if (we[i]) nw[8*i +: 8] = wd[8*i +: 8];
          mdl[w] = nw;
          exp_wr = sat_inc(exp_wr);
        end
      end else begin
        if (we == 4'b0000) begin
          exp_rdata   = ERR_WORD;
          rdata_known = 1'b1;
          exp_rd      = sat_inc(exp_rd);
        end else begin
          exp_wr = sat_inc(exp_wr);
        end
        if (!exp_err) exp_err_addr = addr;
        exp_err = 1'b1;
      end
    end
    check_all(tag);
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  we;
    int          pick;
    n_tests        = 0;
    n_fail         = 0;
    rdata_known    = 1'b1;
    exp_rdata      = '0;
    exp_err        = 1'b0;
    exp_err_addr   = '0;
    exp_rd         = '0;
    exp_wr         = '0;
    resetn         = 1'b0;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'b0000;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;

    cycle(0, 0, 4'h0, 32'h0, 32'h0, "reset0");
    cycle(0, 0, 4'h0, 32'h0, 32'h0, "reset1");

    // Preload words 0..31 through the port.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] d;
      d = (i == 0) ? 32'h0280_0C01 : (i == 5) ? 32'h1122_3344 : $urandom;
      cycle(1, 1, 4'hF, BASE + 32'(4 * i), d, "preload");
    end

    // Test 1: fresh reset then a single read.
    cycle(0, 0, 4'h0, 32'h0, 32'h0, "t1_reset");
    check32("t1_rdata_before", bus.sram_rdata, 32'h0);
    cycle(1, 1, 4'h0, BASE, 32'h0, "t1_read");
    check32("t1_rdata", bus.sram_rdata, 32'h0280_0C01);
    check32("t1_rd_cnt", rd_cnt, 32'd1);

    // Test 2: back-to-back reads stream without bubbles.
    for (int i = 0; i < 3; i++)
      cycle(1, 1, 4'h0, BASE + 32'(4 * i), 32'h0, "t2_stream");

    // Test 3: hold during stall, with junk on the idle bus.
    cycle(1, 1, 4'h0, BASE + 32'h4, 32'h0, "t3_read");
    for (int i = 0; i < 5; i++)
      cycle(1, 0, 4'(($urandom)), $urandom, $urandom, "t3_hold");

    // Test 4: partial write is read-first, then merged.
    cycle(1, 1, 4'b0101, BASE + 32'h14, 32'hAABB_CCDD, "t4_write");
    check32("t4_readfirst", bus.sram_rdata, 32'h1122_3344);
    cycle(1, 1, 4'h0, BASE + 32'h14, 32'h0, "t4_read");
    check32("t4_merged", bus.sram_rdata, 32'h11BB_33DD);

    // Test 5: reads just below and just above the window.
    cycle(1, 1, 4'h0, 32'h1BFF_FFFC, 32'h0, "t5_below");
    check32("t5_below_data", bus.sram_rdata, ERR_WORD);
    cycle(1, 1, 4'h0, 32'h1C04_0000, 32'h0, "t5_above");
    check32("t5_above_data", bus.sram_rdata, ERR_WORD);
    check32("t5_err_addr", err_addr, 32'h1BFF_FFFC);
    cycle(1, 1, 4'hF, 32'h1C04_0000, 32'h0, "t5_oow_write");
    cycle(1, 1, 4'h0, BASE + 32'h3, 32'h0, "t5_unaligned");

    // Test 6: reset mid-stream with a full write pending.
    cycle(1, 1, 4'h0, BASE + 32'h8, 32'h0, "t6_read");
    cycle(0, 1, 4'hF, BASE + 32'h8, 32'hDEAD_BEEF, "t6_reset");
    check32("t6_rd_cnt", rd_cnt, 32'd0);
    cycle(1, 1, 4'h0, BASE + 32'h8, 32'h0, "t6_readback");

    // Random traffic, mostly in-window with occasional strays and resets.
    for (int n = 0; n < 400; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 8)       addr = BASE + 32'($urandom_range(0, 127));
      else if (pick == 8) addr = BASE - 32'($urandom_range(1, 64));
      else                addr = $urandom;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), we, addr, $urandom, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
